// File: rtl/pipe_meta.sv
// pipe_meta: EX/MEM/WB metadata slots feeding hazard/forwarding; ID data shows on EX +1, MEM +2, WB +3 cycles.
// hold freezes every slot; stall/flush_id_ex bubble EX only. PIPE_META_PERF_EN compiles the perf counters.
module pipe_meta (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_id,
  input  logic [4:0]  rs1_addr_id,
  input  logic [4:0]  rs2_addr_id,
  input  logic [4:0]  rd_addr_id,
  input  logic        rd_we_id,
  input  logic        is_load_id,
  input  logic        is_store_id,
  input  logic        stall,
  input  logic        flush_id_ex,
  input  logic        hold,
  output logic [4:0]  rs1_addr_ex,
  output logic [4:0]  rs2_addr_ex,
  output logic [4:0]  rd_addr_ex,
  output logic        rd_we_ex,
  output logic        is_load_ex,
  output logic        valid_ex,
  output logic [4:0]  rs2_addr_mem,
  output logic [4:0]  rd_addr_mem,
  output logic        rd_we_mem,
  output logic        is_load_mem,
  output logic        is_store_mem,
  output logic        valid_mem,
  output logic [4:0]  rd_addr_wb,
  output logic        rd_we_wb,
  output logic        valid_wb,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_retire_cnt
);

  logic       bubble;
  logic       is_store_ex;
  logic       valid_ex_n;
  logic       rd_we_ex_n;
  logic       is_load_ex_n;
  logic       is_store_ex_n;
  logic [4:0] rs1_ex_n;
  logic [4:0] rs2_ex_n;
  logic [4:0] rd_ex_n;

  assign bubble = flush_id_ex | stall;

  // Flags are qualified at capture so a bubble or invalid slot can never carry them downstream.
  always_comb begin
    valid_ex_n    = 1'b0;
    rd_we_ex_n    = 1'b0;
    is_load_ex_n  = 1'b0;
    is_store_ex_n = 1'b0;
    rs1_ex_n      = 5'd0;
    rs2_ex_n      = 5'd0;
    rd_ex_n       = 5'd0;
    if (!bubble) begin
      valid_ex_n    = valid_id;
      rd_we_ex_n    = rd_we_id & valid_id & (rd_addr_id != 5'd0);
      is_load_ex_n  = is_load_id & valid_id;
      is_store_ex_n = is_store_id & valid_id;
      rs1_ex_n      = rs1_addr_id;
      rs2_ex_n      = rs2_addr_id;
      rd_ex_n       = rd_addr_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_ex     <= 1'b0;
      rd_we_ex     <= 1'b0;
      is_load_ex   <= 1'b0;
      is_store_ex  <= 1'b0;
      rs1_addr_ex  <= 5'd0;
      rs2_addr_ex  <= 5'd0;
      rd_addr_ex   <= 5'd0;
      valid_mem    <= 1'b0;
      rd_we_mem    <= 1'b0;
      is_load_mem  <= 1'b0;
      is_store_mem <= 1'b0;
      rs2_addr_mem <= 5'd0;
      rd_addr_mem  <= 5'd0;
      valid_wb     <= 1'b0;
      rd_we_wb     <= 1'b0;
      rd_addr_wb   <= 5'd0;
    end else if (!hold) begin
      valid_ex     <= valid_ex_n;
      rd_we_ex     <= rd_we_ex_n;
      is_load_ex   <= is_load_ex_n;
      is_store_ex  <= is_store_ex_n;
      rs1_addr_ex  <= rs1_ex_n;
      rs2_addr_ex  <= rs2_ex_n;
      rd_addr_ex   <= rd_ex_n;
      valid_mem    <= valid_ex;
      rd_we_mem    <= rd_we_ex;
      is_load_mem  <= is_load_ex;
      is_store_mem <= is_store_ex;
      rs2_addr_mem <= rs2_addr_ex;
      rd_addr_mem  <= rd_addr_ex;
      valid_wb     <= valid_mem;
      rd_we_wb     <= rd_we_mem;
      rd_addr_wb   <= rd_addr_mem;
    end
  end

`ifdef PIPE_META_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;
  logic [31:0] retire_cnt_q;

  // A flush coinciding with a stall is one bubble, already counted as a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= 32'd0;
      flush_cnt_q  <= 32'd0;
      retire_cnt_q <= 32'd0;
    end else if (!hold) begin
      if (stall)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_id_ex && !stall)
        flush_cnt_q <= flush_cnt_q + 32'd1;
      if (valid_wb)
        retire_cnt_q <= retire_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt  = stall_cnt_q;
  assign perf_flush_cnt  = flush_cnt_q;
  assign perf_retire_cnt = retire_cnt_q;
`else
  assign perf_stall_cnt  = 32'd0;
  assign perf_flush_cnt  = 32'd0;
  assign perf_retire_cnt = 32'd0;
`endif

endmodule
